// File: rtl/doorlock_pkg.sv
// Shared key codes, FSM state encoding and keypad decode helpers for the
// multi-digit door lock.
package doorlock_pkg;

    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam logic [3:0] KEY_SET  = 4'd10;
    localparam logic [3:0] KEY_CLR  = 4'd11;
    localparam logic [3:0] KEY_ENT  = 4'd12;
    localparam logic [3:0] KEY_ZERO = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTRY     = 3'd1,
        ST_SET_ENTRY = 3'd2,
        ST_UNLOCKED  = 3'd3,
        ST_LOCKOUT   = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return ((key >= 4'd1) && (key <= 4'd9)) || (key == KEY_ZERO);
    endfunction

    // Key 13 is the zero digit; non-digit codes map to 0 but are never shifted in.
    function automatic logic [3:0] key_to_bcd(input logic [3:0] key);
        logic [3:0] bcd;
        case (key)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9: bcd = key;
            default:                bcd = 4'd0;
        endcase
        return bcd;
    endfunction

endpackage

// File: rtl/keypad_edge.sv
// Press detector: one key event on the first cycle a nonzero code appears
// after a released keypad.
import doorlock_pkg::*;

module keypad_edge (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_button,
    output logic       o_key_valid,
    output logic [3:0] o_key_code
);

    logic [3:0] r_prev_button;

    // Previous keypad sample for edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev_button <= KEY_NONE;
        end else begin
            r_prev_button <= i_button;
        end
    end

    assign o_key_valid = (r_prev_button == KEY_NONE) && (i_button != KEY_NONE);
    assign o_key_code  = i_button;

endmodule

// File: rtl/doorlock_multi.sv
// Multi-digit keypad door lock: code entry, fingerprint-gated password change,
// failed-attempt lockout, timed unlock and entry inactivity timeout.
import doorlock_pkg::*;

module doorlock_multi #(
    parameter int                    PW_LEN         = 8,
    parameter int                    FP_W           = 8,
    parameter logic [FP_W-1:0]       FP_ID          = 8'h97,
    parameter logic [PW_LEN*4-1:0]   DEFAULT_PW     = 32'h1234_5678,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    UNLOCK_CYCLES  = 10,
    parameter int                    LOCK_CYCLES    = 50,
    parameter int                    TIMEOUT_CYCLES = 100
) (
    input  logic                  sync_clk,
    input  logic                  sync_rst_n,
    input  logic [3:0]            button,
    input  logic [FP_W-1:0]       fingerprint,
    output logic [PW_LEN*4-1:0]   display,
    output logic [3:0]            entry_cnt,
    output logic                  unlock,
    output logic                  locked_out,
    output logic                  set_mode,
    output logic                  pw_updated,
    output logic [1:0]            fail_cnt
);

    localparam int BUF_W   = PW_LEN * 4;
    localparam int T_UL    = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int T_MAX   = (T_UL > TIMEOUT_CYCLES) ? T_UL : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(T_MAX + 1);
    localparam logic [BUF_W-1:0] BUF_EMPTY = {PW_LEN{4'hF}};
    localparam logic [1:0]       FAIL_LIM  = 2'(MAX_FAIL);
    localparam logic [3:0]       LEN_4     = 4'(PW_LEN);

    logic             w_key_valid;
    logic [3:0]       w_key_code;

    state_t           r_state, w_state_nx;
    logic [BUF_W-1:0] r_buf, w_buf_nx, w_buf_shift;
    logic [BUF_W-1:0] r_pw, w_pw_nx;
    logic [3:0]       r_cnt, w_cnt_nx;
    logic [TMR_W-1:0] r_tmr, w_tmr_nx;
    logic [1:0]       r_fail, w_fail_nx, w_fail_inc;
    logic             w_pw_upd_nx;
    logic             r_unlock, r_locked_out, r_set_mode, r_pw_upd;

    keypad_edge u_keypad_edge (
        .i_clk       (sync_clk),
        .i_rst_n     (sync_rst_n),
        .i_button    (button),
        .o_key_valid (w_key_valid),
        .o_key_code  (w_key_code)
    );

    // New digit enters on the LSD side; the oldest nibble falls off the top.
    assign w_buf_shift = BUF_W'({r_buf, key_to_bcd(w_key_code)});
    assign w_fail_inc  = r_fail + 2'd1;

    // Next-state, buffer, password, timer and failure-count logic
    always_comb begin
        w_state_nx  = r_state;
        w_buf_nx    = r_buf;
        w_pw_nx     = r_pw;
        w_cnt_nx    = r_cnt;
        w_tmr_nx    = r_tmr;
        w_fail_nx   = r_fail;
        w_pw_upd_nx = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tmr_nx = '0;
                if (w_key_valid && is_digit(w_key_code)) begin
                    w_buf_nx   = w_buf_shift;
                    w_cnt_nx   = 4'd1;
                    w_state_nx = ST_ENTRY;
                end else if (w_key_valid && (w_key_code == KEY_SET)) begin
                    if (fingerprint == FP_ID) begin
                        w_state_nx = ST_SET_ENTRY;
                    end else begin
                        w_fail_nx  = w_fail_inc;
                        w_state_nx = (w_fail_inc == FAIL_LIM) ? ST_LOCKOUT : ST_IDLE;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end

            ST_ENTRY, ST_SET_ENTRY: begin
                if (w_key_valid) begin
                    // A key in the timeout cycle still wins and restarts the timer.
                    w_tmr_nx = '0;
                    if (is_digit(w_key_code)) begin
                        if (r_cnt < LEN_4) begin
                            w_buf_nx = w_buf_shift;
                            w_cnt_nx = r_cnt + 4'd1;
                        end else begin
                            w_cnt_nx = r_cnt;
                        end
                    end else if (w_key_code == KEY_CLR) begin
                        w_buf_nx   = BUF_EMPTY;
                        w_cnt_nx   = 4'd0;
                        w_state_nx = ST_IDLE;
                    end else if (w_key_code == KEY_ENT) begin
                        w_buf_nx = BUF_EMPTY;
                        w_cnt_nx = 4'd0;
                        if (r_state == ST_SET_ENTRY) begin
                            w_state_nx = ST_IDLE;
                            if (r_cnt == LEN_4) begin
                                w_pw_nx     = r_buf;
                                w_pw_upd_nx = 1'b1;
                            end else begin
                                w_pw_nx = r_pw;
                            end
                        end else if ((r_cnt == LEN_4) && (r_buf == r_pw)) begin
                            w_fail_nx  = 2'd0;
                            w_state_nx = ST_UNLOCKED;
                        end else begin
                            w_fail_nx  = w_fail_inc;
                            w_state_nx = (w_fail_inc == FAIL_LIM) ? ST_LOCKOUT : ST_IDLE;
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end else if (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    w_buf_nx   = BUF_EMPTY;
                    w_cnt_nx   = 4'd0;
                    w_tmr_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_tmr_nx = r_tmr + TMR_W'(1);
                end
            end

            ST_UNLOCKED: begin
                if (r_tmr == TMR_W'(UNLOCK_CYCLES - 1)) begin
                    w_tmr_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_tmr_nx = r_tmr + TMR_W'(1);
                end
            end

            ST_LOCKOUT: begin
                if (r_tmr == TMR_W'(LOCK_CYCLES - 1)) begin
                    w_tmr_nx   = '0;
                    w_fail_nx  = 2'd0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_tmr_nx = r_tmr + TMR_W'(1);
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
                w_buf_nx   = BUF_EMPTY;
                w_cnt_nx   = 4'd0;
                w_tmr_nx   = '0;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge sync_clk) begin
        if (!sync_rst_n) begin
            r_state      <= ST_IDLE;
            r_buf        <= BUF_EMPTY;
            r_pw         <= DEFAULT_PW;
            r_cnt        <= 4'd0;
            r_tmr        <= '0;
            r_fail       <= 2'd0;
            r_unlock     <= 1'b0;
            r_locked_out <= 1'b0;
            r_set_mode   <= 1'b0;
            r_pw_upd     <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_buf        <= w_buf_nx;
            r_pw         <= w_pw_nx;
            r_cnt        <= w_cnt_nx;
            r_tmr        <= w_tmr_nx;
            r_fail       <= w_fail_nx;
            r_unlock     <= (w_state_nx == ST_UNLOCKED);
            r_locked_out <= (w_state_nx == ST_LOCKOUT);
            r_set_mode   <= (w_state_nx == ST_SET_ENTRY);
            r_pw_upd     <= w_pw_upd_nx;
        end
    end

    assign display    = r_buf;
    assign entry_cnt  = r_cnt;
    assign unlock     = r_unlock;
    assign locked_out = r_locked_out;
    assign set_mode   = r_set_mode;
    assign pw_updated = r_pw_upd;
    assign fail_cnt   = r_fail;

endmodule

// File: tb/tb_doorlock_multi.sv
// Directed bench for doorlock_multi: table-driven entry vectors plus
// hand-written sequences for timing, lockout, timeout and reset cases.
module tb_doorlock_multi;

    logic        sync_clk;
    logic        sync_rst_n;
    logic [3:0]  button;
    logic [7:0]  fingerprint;
    logic [31:0] display;
    logic [3:0]  entry_cnt;
    logic        unlock;
    logic        locked_out;
    logic        set_mode;
    logic        pw_updated;
    logic [1:0]  fail_cnt;

    int checks   = 0;
    int failures = 0;
    int unl_total = 0;
    int lk_total  = 0;
    int pwu_total = 0;

    typedef struct {
        logic [3:0]  key;
        logic [3:0]  exp_cnt;
        logic [31:0] exp_disp;
        logic        exp_unlock;
    } vec_t;

    vec_t vecs [0:10];

    doorlock_multi dut (
        .sync_clk    (sync_clk),
        .sync_rst_n  (sync_rst_n),
        .button      (button),
        .fingerprint (fingerprint),
        .display     (display),
        .entry_cnt   (entry_cnt),
        .unlock      (unlock),
        .locked_out  (locked_out),
        .set_mode    (set_mode),
        .pw_updated  (pw_updated),
        .fail_cnt    (fail_cnt)
    );

    initial sync_clk = 1'b0;
    always #5 sync_clk = ~sync_clk;

    // Cycle counters for pulse widths, sampled well after each rising edge
    always @(posedge sync_clk) begin
        #2;
        if (unlock)     unl_total = unl_total + 1;
        if (locked_out) lk_total  = lk_total + 1;
        if (pw_updated) pwu_total = pwu_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input logic [7:0] fp);
        @(negedge sync_clk);
        button      = k;
        fingerprint = fp;
        @(negedge sync_clk);
        button      = 4'd0;
    endtask

    task automatic enter_code(input logic [31:0] code);
        for (int i = 7; i >= 0; i--) begin
            logic [3:0] n;
            n = code[i*4 +: 4];
            press((n == 4'd0) ? 4'd13 : n, 8'h00);
        end
        press(4'd12, 8'h00);
    endtask

    task automatic pulse_reset();
        @(negedge sync_clk);
        sync_rst_n = 1'b0;
        @(negedge sync_clk);
        sync_rst_n = 1'b1;
    endtask

    initial begin
        int base;

        vecs[0]  = '{4'd1,  4'd1, 32'hFFFF_FFF1, 1'b0};
        vecs[1]  = '{4'd2,  4'd2, 32'hFFFF_FF12, 1'b0};
        vecs[2]  = '{4'd3,  4'd3, 32'hFFFF_F123, 1'b0};
        vecs[3]  = '{4'd4,  4'd4, 32'hFFFF_1234, 1'b0};
        vecs[4]  = '{4'd5,  4'd5, 32'hFFF1_2345, 1'b0};
        vecs[5]  = '{4'd6,  4'd6, 32'hFF12_3456, 1'b0};
        vecs[6]  = '{4'd7,  4'd7, 32'hF123_4567, 1'b0};
        vecs[7]  = '{4'd8,  4'd8, 32'h1234_5678, 1'b0};
        vecs[8]  = '{4'd9,  4'd8, 32'h1234_5678, 1'b0};
        vecs[9]  = '{4'd13, 4'd8, 32'h1234_5678, 1'b0};
        vecs[10] = '{4'd12, 4'd0, 32'hFFFF_FFFF, 1'b1};

        button      = 4'd0;
        fingerprint = 8'h00;
        sync_rst_n  = 1'b0;
        repeat (3) @(negedge sync_clk);
        sync_rst_n = 1'b1;

        check("rst_display", display, 32'hFFFF_FFFF);
        check("rst_entry_cnt", {28'd0, entry_cnt}, 32'd0);
        check("rst_flags", {28'd0, unlock, locked_out, set_mode, pw_updated}, 32'd0);
        check("rst_fail_cnt", {30'd0, fail_cnt}, 32'd0);

        // Default code with overflow digits, then ENTER
        base = unl_total;
        for (int i = 0; i < 11; i++) begin
            press(vecs[i].key, 8'h00);
            check($sformatf("vec%0d_cnt", i), {28'd0, entry_cnt}, {28'd0, vecs[i].exp_cnt});
            check($sformatf("vec%0d_disp", i), display, vecs[i].exp_disp);
            check($sformatf("vec%0d_unlock", i), {31'd0, unlock}, {31'd0, vecs[i].exp_unlock});
        end
        repeat (15) @(negedge sync_clk);
        check("unlock_width", unl_total - base, 32'd10);
        check("unlock_fail_cnt", {30'd0, fail_cnt}, 32'd0);
        check("unlock_over", {31'd0, unlock}, 32'd0);

        // Password change with valid fingerprint
        press(4'd10, 8'h97);
        check("set_mode_on", {31'd0, set_mode}, 32'd1);
        base = pwu_total;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pw;
            pw = 32'h5749_1726;
            press(pw[(7-i)*4 +: 4], 8'h00);
        end
        press(4'd12, 8'h00);
        check("pw_updated_pulse", {31'd0, pw_updated}, 32'd1);
        @(negedge sync_clk);
        check("pw_updated_drop", {31'd0, pw_updated}, 32'd0);
        check("pw_updated_width", pwu_total - base, 32'd1);
        check("set_mode_off", {31'd0, set_mode}, 32'd0);

        enter_code(32'h5749_1726);
        check("new_pw_unlock", {31'd0, unlock}, 32'd1);
        repeat (15) @(negedge sync_clk);
        enter_code(32'h1234_5678);
        check("old_pw_no_unlock", {31'd0, unlock}, 32'd0);
        check("old_pw_fail1", {30'd0, fail_cnt}, 32'd1);

        // Success clears the count, then three failures lock out
        enter_code(32'h5749_1726);
        check("success_clears_fail", {30'd0, fail_cnt}, 32'd0);
        repeat (15) @(negedge sync_clk);
        enter_code(32'h1111_1111);
        check("wrong1_fail", {30'd0, fail_cnt}, 32'd1);
        enter_code(32'h1111_1111);
        check("wrong2_fail", {30'd0, fail_cnt}, 32'd2);
        base = lk_total;
        enter_code(32'h1111_1111);
        check("lockout_on", {31'd0, locked_out}, 32'd1);
        check("lockout_fail", {30'd0, fail_cnt}, 32'd3);
        enter_code(32'h5749_1726);
        check("lockout_no_unlock", {31'd0, unlock}, 32'd0);
        check("lockout_keys_ignored", {28'd0, entry_cnt}, 32'd0);
        press(4'd10, 8'h97);
        check("lockout_set_ignored", {31'd0, set_mode}, 32'd0);
        repeat (40) @(negedge sync_clk);
        check("lockout_width", lk_total - base, 32'd50);
        check("lockout_off", {31'd0, locked_out}, 32'd0);
        check("lockout_fail_clear", {30'd0, fail_cnt}, 32'd0);
        enter_code(32'h5749_1726);
        check("post_lockout_unlock", {31'd0, unlock}, 32'd1);
        repeat (15) @(negedge sync_clk);

        // Wrong fingerprint, then inactivity timeout
        press(4'd10, 8'h00);
        check("bad_fp_set_mode", {31'd0, set_mode}, 32'd0);
        check("bad_fp_fail", {30'd0, fail_cnt}, 32'd1);
        press(4'd3, 8'h00);
        check("timeout_pre_cnt", {28'd0, entry_cnt}, 32'd1);
        repeat (90) @(negedge sync_clk);
        check("timeout_not_yet", {28'd0, entry_cnt}, 32'd1);
        repeat (15) @(negedge sync_clk);
        check("timeout_cnt", {28'd0, entry_cnt}, 32'd0);
        check("timeout_disp", display, 32'hFFFF_FFFF);
        check("timeout_fail_kept", {30'd0, fail_cnt}, 32'd1);

        // Held key gives a single event; CLEAR empties without a failure
        @(negedge sync_clk);
        button = 4'd7;
        repeat (20) @(negedge sync_clk);
        button = 4'd0;
        check("held_key_cnt", {28'd0, entry_cnt}, 32'd1);
        check("held_key_disp", display, 32'hFFFF_FFF7);
        press(4'd11, 8'h00);
        check("clear_cnt", {28'd0, entry_cnt}, 32'd0);
        check("clear_fail_kept", {30'd0, fail_cnt}, 32'd1);

        // Reset during UNLOCKED and during LOCKOUT
        enter_code(32'h5749_1726);
        check("pre_rst_unlock", {31'd0, unlock}, 32'd1);
        repeat (3) @(negedge sync_clk);
        pulse_reset();
        check("rst_mid_unlock", {31'd0, unlock}, 32'd0);
        enter_code(32'h1234_5678);
        check("rst_pw_reverted", {31'd0, unlock}, 32'd1);
        repeat (15) @(negedge sync_clk);
        enter_code(32'h1111_1111);
        enter_code(32'h1111_1111);
        enter_code(32'h1111_1111);
        check("pre_rst_locked", {31'd0, locked_out}, 32'd1);
        repeat (5) @(negedge sync_clk);
        pulse_reset();
        check("rst_mid_lockout", {31'd0, locked_out}, 32'd0);
        check("rst_mid_lockout_fail", {30'd0, fail_cnt}, 32'd0);
        enter_code(32'h1234_5678);
        check("rst_lockout_unlock", {31'd0, unlock}, 32'd1);
        repeat (15) @(negedge sync_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
